fig450_symbol_tx: RTL and testbench

Transmit-side encoder for the Figure 4.50 Mealy receiver (2-bit symbol input X, registered output Z, states A/B/C/D). It accepts parallel data words over a valid/ready handshake and emits one symbol per clock. Each symbol is chosen so that the receiver's Z output reproduces the data bits, LSB first. It keeps a mirror of the receiver's state so that it always selects a symbol that produces the wanted Z for the receiver's current state. It sits on the driving side of the receiver's X bus, and both blocks share CLK and Reset.

---
 rtl/fig450_symbol_tx.sv | 135 +++++++++++++
 tb/tb_fig450_symbol_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fig450_symbol_tx.sv
// fig450_symbol_tx: transmit-side encoder for the Figure 4.50 Mealy receiver.
// Serialises WIDTH-bit words LSB first, choosing each 2-bit symbol from a
// mirror of the receiver state so that the receiver's Z reproduces the data.
// Optional feature: define PARITY_TX_EN to append an even-parity symbol.
module fig450_symbol_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  output logic [2:1]       X,
  output logic             X_valid,
  output logic             Busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef PARITY_TX_EN
  localparam int unsigned LAST = WIDTH;
`else
  localparam int unsigned LAST = WIDTH - 1;
`endif

  localparam logic [1:0] ST_A = 2'b00;
  localparam logic [1:0] ST_B = 2'b01;
  localparam logic [1:0] ST_C = 2'b10;

  typedef enum logic {IDLE, SEND} state_t;

  // Receiver next-state function, reproduced exactly
  function automatic logic [1:0] rx_next(input logic [1:0] s, input logic [1:0] x);
    case (s)
      ST_A:    rx_next = (x == 2'b00 || x == 2'b11) ? ST_A : ST_B;
      ST_B:    rx_next = (x == 2'b00 || x == 2'b01) ? ST_A : 2'b11;
      ST_C:    rx_next = (x == 2'b10 || x == 2'b11) ? ST_C : ST_A;
      default: rx_next = (x == 2'b00 || x == 2'b11) ? ST_C : ST_B;
    endcase
  endfunction

  // Symbol that makes the receiver emit Z=d from state s
  function automatic logic [1:0] tx_sym(input logic [1:0] s, input logic d);
    case (s)
      ST_A, ST_B: tx_sym = d ? 2'b10 : 2'b00;
      ST_C:       tx_sym = d ? 2'b10 : 2'b01;
      default:    tx_sym = d ? 2'b00 : 2'b10;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       s_q, s_d;
  logic [1:0]       x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             send_bit, bit_d, last;
`ifdef PARITY_TX_EN
  logic             par_q, par_d;
`endif

  // State, symbol and mirror registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      s_q       <= ST_A;
      x_q       <= 2'b00;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PARITY_TX_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
`ifdef PARITY_TX_EN
      par_q     <= par_d;
`endif
    end
  end

  // Next-state, symbol selection and mirror update
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    send_bit = 1'b0;
    bit_d    = 1'b0;
`ifdef PARITY_TX_EN
    par_d    = par_q;
`endif
    last      = (state_q == SEND) && (cnt_q == CW'(LAST));
    Din_ready = (state_q == IDLE) || last;

    if (Din_valid && Din_ready) begin
      state_d  = SEND;
      sr_d     = Din;
      cnt_d    = '0;
      send_bit = 1'b1;
      bit_d    = Din[0];
`ifdef PARITY_TX_EN
      par_d    = ^Din;
`endif
    end else if ((state_q == SEND) && !last) begin
      sr_d     = sr_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      send_bit = 1'b1;
`ifdef PARITY_TX_EN
      bit_d    = (cnt_q == CW'(WIDTH - 1)) ? par_q : sr_q[1];
`else
      bit_d    = sr_q[1];
`endif
    end else begin
      state_d  = IDLE;
    end

    // Idle symbol 00 steers the receiver back toward A
    x_d       = send_bit ? tx_sym(s_q, bit_d) : 2'b00;
    x_valid_d = send_bit;
    busy_d    = send_bit;
    s_d       = rx_next(s_q, x_d);
  end

  assign X       = x_q;
  assign X_valid = x_valid_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_fig450_symbol_tx.sv
// Testbench for fig450_symbol_tx: directed vector table, hand sequences for
// reset abort, and random frames checked through an attached receiver model.
module tb_fig450_symbol_tx;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Din = 8'h00;
  logic       Din_valid = 1'b0;
  logic       Din_ready;
  logic [2:1] X;
  logic       X_valid;
  logic       Busy;

  initial forever #5 CLK = ~CLK;

  fig450_symbol_tx #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Din       (Din),
    .Din_valid (Din_valid),
    .Din_ready (Din_ready),
    .X         (X),
    .X_valid   (X_valid),
    .Busy      (Busy)
  );

  typedef struct {
    logic [7:0]  word;
    logic        b2b;
    logic [15:0] exp_x;
    logic [15:0] exp_xp;
    logic [1:0]  p9;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic       q[$];
  logic [1:0] ms = 2'b00;
  logic [1:0] rq = 2'b00;
  logic [1:0] last_x = 2'b00;
  logic       last_valid = 1'b0;
  logic       last_bit = 1'b0;
  logic [1:0] xlog[0:16383];
  int         xn = 0;
  vec_t       vecs[5];

  function automatic logic [1:0] tb_next(input logic [1:0] s, input logic [1:0] x);
    case (s)
      2'b00:   return (x == 2'b00 || x == 2'b11) ? 2'b00 : 2'b01;
      2'b01:   return (x == 2'b00 || x == 2'b01) ? 2'b00 : 2'b11;
      2'b10:   return (x == 2'b10 || x == 2'b11) ? 2'b10 : 2'b00;
      default: return (x == 2'b00 || x == 2'b11) ? 2'b10 : 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] tb_sym(input logic [1:0] s, input logic d);
    case (s)
      2'b00, 2'b01: return d ? 2'b10 : 2'b00;
      2'b10:        return d ? 2'b10 : 2'b01;
      default:      return d ? 2'b00 : 2'b10;
    endcase
  endfunction

  // Receiver Z decode; 2'b10 marks a symbol that carries no data bit
  function automatic logic [1:0] tb_z(input logic [1:0] s, input logic [1:0] x);
    case (s)
      2'b00, 2'b01: return (x == 2'b00) ? 2'b00 : (x == 2'b10) ? 2'b01 : 2'b10;
      2'b10:        return (x == 2'b01) ? 2'b00 : (x == 2'b10) ? 2'b01 : 2'b10;
      default:      return (x == 2'b10) ? 2'b00 : (x == 2'b00) ? 2'b01 : 2'b10;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance scoreboard and receiver model, compare
  task automatic step(input logic v, input logic [7:0] d);
    logic       acc, cur, cv;
    logic [1:0] ex, zr;
    Din_valid = v;
    Din       = d;
    chk("din_ready", 16'(Din_ready), 16'(q.size() == 0));
    acc = v && (q.size() == 0);
    @(posedge CLK);
    #1;
    if (acc) begin
      for (int j = 0; j < 8; j++) q.push_back(d[j]);
`ifdef PARITY_TX_EN
      q.push_back(^d);
`endif
    end
    zr = tb_z(rq, last_x);
    rq = tb_next(rq, last_x);
    if (last_valid) chk("rx_z", 16'(zr), 16'({1'b0, last_bit}));
    chk("s_vs_rx_q", 16'(rq), 16'(ms));
    cv  = q.size() > 0;
    cur = 1'b0;
    if (cv) cur = q.pop_front();
    ex = cv ? tb_sym(ms, cur) : 2'b00;
    ms = tb_next(ms, ex);
    chk("x", 16'(X), 16'(ex));
    chk("x_valid", 16'(X_valid), 16'(cv));
    chk("busy", 16'(Busy), 16'(cv));
    chk("s_mirror", 16'(dut.s_q), 16'(ms));
    last_x     = X;
    last_valid = cv;
    last_bit   = cur;
    if (xn < 16384) begin
      xlog[xn] = X;
      xn++;
    end
  endtask

  task automatic idle_to_a();
    for (int k = 0; k < 6; k++)
      if (!(q.size() == 0 && ms == 2'b00)) step(1'b0, 8'h00);
    chk("idle_at_a", 16'(dut.s_q), 16'h0000);
  endtask

  task automatic check_frame(input string name, input int start,
                             input logic [15:0] exp, input logic [1:0] p9);
    logic [15:0] got;
    got = '0;
    for (int k = 0; k < 8; k++) got[2*k +: 2] = xlog[start + k];
    chk(name, got, exp);
`ifdef PARITY_TX_EN
    chk({name, "_par"}, 16'(xlog[start + 8]), 16'(p9));
`else
    if (p9 == 2'b11) chk({name, "_p9"}, 16'(p9), 16'h0000);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int   start;
    int   frames;
    int   cycles;
    logic chain;
    logic v;
    logic [7:0] w;

    vecs[0] = '{word: 8'hA5, b2b: 1'b0, exp_x: 16'h8822, exp_xp: 16'h8822, p9: 2'b00};
    vecs[1] = '{word: 8'hFF, b2b: 1'b1, exp_x: 16'hAA8A, exp_xp: 16'hAA8A, p9: 2'b01};
    vecs[2] = '{word: 8'h00, b2b: 1'b0, exp_x: 16'h0001, exp_xp: 16'h0000, p9: 2'b00};
    vecs[3] = '{word: 8'h01, b2b: 1'b0, exp_x: 16'h0002, exp_xp: 16'h0002, p9: 2'b10};
    vecs[4] = '{word: 8'h07, b2b: 1'b0, exp_x: 16'h004A, exp_xp: 16'h004A, p9: 2'b10};

    // Reset state
    #3;
    chk("rst_x", 16'(X), 16'h0000);
    chk("rst_x_valid", 16'(X_valid), 16'h0000);
    chk("rst_busy", 16'(Busy), 16'h0000);
    chk("rst_s", 16'(dut.s_q), 16'h0000);
    @(negedge CLK);
    Reset = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00);

    // Directed vector table
    chain = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!chain) idle_to_a();
      start = xn;
      step(1'b1, vecs[i].word);
      while (q.size() > 0)
        step(1'b1, (vecs[i].b2b && i < 4) ? vecs[i+1].word : 8'h3C);
`ifdef PARITY_TX_EN
      check_frame("frame_x", start, vecs[i].exp_xp, vecs[i].p9);
`else
      check_frame("frame_x", start, vecs[i].exp_x, vecs[i].p9);
`endif
      chain = vecs[i].b2b;
    end

    // Reset during the 4th symbol of 8'hFF aborts the frame
    idle_to_a();
    step(1'b1, 8'hFF);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00);
    #1 Reset = 1'b1;
    #1;
    chk("abort_x", 16'(X), 16'h0000);
    chk("abort_x_valid", 16'(X_valid), 16'h0000);
    chk("abort_busy", 16'(Busy), 16'h0000);
    chk("abort_s", 16'(dut.s_q), 16'h0000);
    chk("abort_ready", 16'(Din_ready), 16'h0001);
    q.delete();
    ms = 2'b00; rq = 2'b00; last_x = 2'b00; last_valid = 1'b0;
    #2 Reset = 1'b0;
    start = xn;
    step(1'b1, 8'h01);
    while (q.size() > 0) step(1'b0, 8'h00);
    check_frame("after_abort", start, 16'h0002, 2'b10);

    // Random frames with random valid gaps
    frames = 0;
    cycles = 0;
    while (frames < 1000 && cycles < 40000) begin
      v = ($urandom_range(0, 3) != 0);
      w = 8'($urandom);
      if (v && q.size() == 0) frames++;
      step(v, w);
      cycles++;
    end
    chk("random_frames", 16'(frames >= 1000), 16'h0001);
    for (int k = 0; k < 12; k++) step(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
